// File: rtl/dog_frame_sched.sv
// Ping-pong frame scheduler for the DoG read path: tracks two frame slots,
// launches the two-pass read sweep when a slot is full and frees it after drain.
module dog_frame_sched #(
    parameter int ROW_LEN  = 262,
    parameter int ROWS     = 512,
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_in_done,
    input  logic       abort,
    output logic       frame_in_ready,
    output logic       wr_bank,
    output logic       rd_start,
    output logic       rd_bank,
    output logic       rd_pass,
    output logic [9:0] rd_row,
    output logic [8:0] rd_col,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] slot_full,
    output logic       overrun
);

    localparam logic [9:0] ROW_LAST   = 10'(ROWS - 1);
    localparam logic [9:0] ROW_HALF   = 10'(ROWS / 2);
    localparam logic [8:0] COL_LAST   = 9'(ROW_LEN - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] drain_cnt;
    logic [1:0] slot_clr;
    logic [1:0] slot_set;
    logic       accept;

    // A slot being freed this cycle may be refilled in the same cycle.
    assign frame_in_ready = !slot_full[wr_bank] || (state == S_DONE && rd_bank == wr_bank);
    assign accept         = frame_in_done && frame_in_ready;

    assign rd_start   = (state == S_START);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign rd_pass    = (rd_row >= ROW_HALF);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        slot_clr = '0;
        slot_set = '0;
        if (state == S_DONE) slot_clr[rd_bank] = 1'b1;
        if (accept)          slot_set[wr_bank] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            slot_full <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            drain_cnt <= '0;
            overrun   <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            slot_full <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            drain_cnt <= '0;
        end else begin
            // Clear before set: a refill in the DONE cycle leaves the slot full.
            slot_full <= (slot_full & ~slot_clr) | slot_set;
            if (accept)             wr_bank <= ~wr_bank;
            else if (frame_in_done) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (slot_full[rd_bank]) state <= S_START;
                end
                S_START: begin
                    rd_row <= '0;
                    rd_col <= '0;
                    state  <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (rd_col == COL_LAST) begin
                        rd_col <= '0;
                        if (rd_row == ROW_LAST) begin
                            rd_row    <= '0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            rd_row <= rd_row + 10'd1;
                        end
                    end else begin
                        rd_col <= rd_col + 9'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= S_DONE;
                    else                         drain_cnt <= drain_cnt + 4'd1;
                end
                S_DONE: begin
                    rd_bank <= ~rd_bank;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dog_frame_sched.sv
// Scoreboard bench for dog_frame_sched: a timeline model predicts start/done pulses
// and per-cycle slot/counter state; a negedge monitor compares against the DUT.
module tb_dog_frame_sched;

    localparam int RL = 6;
    localparam int NR = 4;
    localparam int PL = 2;
    localparam int FT = 1 + RL * NR + PL;  // rd_start to frame_done distance

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_in_done = 1'b0;
    logic       abort = 1'b0;
    logic       frame_in_ready, wr_bank, rd_start, rd_bank, rd_pass;
    logic [9:0] rd_row;
    logic [8:0] rd_col;
    logic       busy, frame_done, overrun;
    logic [1:0] slot_full;

    always #5 clk = ~clk;

    dog_frame_sched #(.ROW_LEN(RL), .ROWS(NR), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .frame_in_done(frame_in_done), .abort(abort),
        .frame_in_ready(frame_in_ready), .wr_bank(wr_bank), .rd_start(rd_start),
        .rd_bank(rd_bank), .rd_pass(rd_pass), .rd_row(rd_row), .rd_col(rd_col),
        .busy(busy), .frame_done(frame_done), .slot_full(slot_full), .overrun(overrun)
    );

    typedef struct {
        int kind;  // 0 = rd_start, 1 = frame_done
        int cyc;
        int bank;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    // Model: slot flags plus the cycle at which the current frame started (-1 = idle).
    bit       m_valid = 1'b0;
    bit [1:0] m_sf;
    bit       m_wr, m_rd, m_ovr;
    int       m_start = -1;
    bit       m_rdy;
    bit [1:0] m_sf_n;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_ready();
        return !m_sf[m_wr] || (m_start >= 0 && cyc - m_start == FT && m_rd == m_wr);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_sf = '0; m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0; m_start = -1;
            exp_q.delete();
        end else if (m_valid) begin
            if (abort) begin
                m_sf = '0; m_wr = 1'b0; m_rd = 1'b0; m_start = -1;
                exp_q.delete();
            end else begin
                m_rdy  = m_ready();
                m_sf_n = m_sf;
                if (m_start < 0) begin
                    if (m_sf[m_rd]) begin
                        m_start = cyc + 1;
                        exp_q.push_back('{0, cyc + 1, int'(m_rd)});
                        exp_q.push_back('{1, cyc + 1 + FT, int'(m_rd)});
                    end
                end else if (cyc - m_start == FT) begin
                    m_sf_n[m_rd] = 1'b0;
                    m_rd = ~m_rd;
                    m_start = -1;
                end
                if (frame_in_done) begin
                    if (m_rdy) begin
                        m_sf_n[m_wr] = 1'b1;
                        m_wr = ~m_wr;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                m_sf = m_sf_n;
            end
        end
        cyc++;
    end

    // Monitor: per-cycle state plus scoreboard pops on every start/done pulse.
    always @(negedge clk) begin
        if (m_valid) begin
            int e, k, er, ec, ep;
            ev_t ev;
            e  = (m_start >= 0) ? cyc - m_start : -1;
            er = 0; ec = 0; ep = 0;
            if (e >= 1 && e <= RL * NR) begin
                k  = e - 1;
                er = k / RL;
                ec = k % RL;
                ep = (er >= NR / 2) ? 1 : 0;
            end
            check("slot_full", int'(slot_full), int'(m_sf));
            check("wr_bank", int'(wr_bank), int'(m_wr));
            check("rd_bank", int'(rd_bank), int'(m_rd));
            check("frame_in_ready", int'(frame_in_ready), int'(m_ready()));
            check("overrun", int'(overrun), int'(m_ovr));
            check("busy", int'(busy), (m_start >= 0) ? 1 : 0);
            check("rd_row", int'(rd_row), er);
            check("rd_col", int'(rd_col), ec);
            check("rd_pass", int'(rd_pass), ep);
            if (rd_start || frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(frame_done) * 2 + int'(rd_start), 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", int'(frame_done), ev.kind);
                    check("pulse_cycle", cyc, ev.cyc);
                    check("pulse_bank", int'(rd_bank), ev.bank);
                end
            end
        end
    end

    task automatic step(input bit f, input bit a, input bit r);
        @(posedge clk);
        #2;
        frame_in_done = f;
        abort = a;
        rst = r;
    endtask

    // Drive the cycle that is currently in progress, then release.
    task automatic pulse_now(input bit f, input bit a, input bit r);
        frame_in_done = f;
        abort = a;
        rst = r;
        step(0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic wait_phase(input int e, input string name);
        int k;
        k = 0;
        while (!(m_start >= 0 && cyc - m_start == e) && k < 200) begin
            step(0, 0, 0);
            k++;
        end
        check(name, (k < 200) ? 1 : 0, 1);
    endtask

    initial begin
        step(0, 0, 1);
        step(0, 0, 0);
        idle(3);

        // Single frame end to end.
        step(1, 0, 0);
        step(0, 0, 0);
        idle(35);

        // Two back-to-back frames, then a third write while both slots are full.
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        idle(3);
        step(1, 0, 0);
        step(0, 0, 0);
        idle(70);

        // Clear overrun, fill both slots, refill slot 0 in its own DONE cycle.
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        wait_phase(FT, "wait_done_cycle");
        pulse_now(1, 0, 0);
        idle(90);

        // Abort in row 1 of the sweep.
        step(1, 0, 0);
        step(0, 0, 0);
        wait_phase(RL + 3, "wait_row1");
        pulse_now(0, 1, 0);
        idle(40);

        // Reset during drain.
        step(1, 0, 0);
        step(0, 0, 0);
        wait_phase(RL * NR + 1, "wait_drain");
        pulse_now(0, 0, 1);
        idle(40);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 6) == 0, ($urandom % 250) == 0, ($urandom % 700) == 0);
        end
        idle(60);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
